// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and the inverse/forward byte-level primitives
// used by the iterative inverse cipher.
package aes_pkg;
  localparam int NR    = 10;
  localparam int BLK_W = 128;
  localparam logic [31:0] IMC_COEF = 32'h0e0b0d09;

  typedef logic [BLK_W-1:0] blk_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_ROUND, ST_HOLD} state_e;

  function automatic bit rpc_legal(input int rpc);
    return (rpc == 1) || (rpc == 2) || (rpc == 5);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, as the S-box needs
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t o;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(IMC_COEF[31-8*((j-r+4)%4) -: 8], s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic blk_t key_exp_step(input blk_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out handshake bundle for the iterative inverse cipher.
interface aes_inv_cipher_iter_if;
  import aes_pkg::*;
  logic in_valid;
  logic in_ready;
  blk_t in_data;
  blk_t in_key;
  logic out_valid;
  logic out_ready;
  blk_t out_data;
  logic busy;

  modport master (output in_valid, in_data, in_key, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_data, in_key, out_ready,
                  output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/aes_inv_cipher_iter_inv_key_step.sv
// Inverse AES-128 key-schedule step: recovers round key r from round key r+1 and rcon(r+1).
module inv_key_step
  import aes_pkg::*;
(
  input  blk_t       k_next_i,
  input  logic [7:0] rcon_i,
  output blk_t       k_o
);
  logic [31:0] n0, n1, n2, n3, w3;

  assign {n0, n1, n2, n3} = k_next_i;
  assign w3  = n3 ^ n2;
  assign k_o = {n0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h0}, n1 ^ n0, n2 ^ n1, w3};
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: RPC inverse rounds per clock, optional key
// pre-expansion with a one-entry round-key-10 cache.
//   state  | meaning
//   IDLE   | ready for a block
//   EXPAND | forward key schedule, one step per cycle, to reach round key 10
//   ROUND  | RPC inverse rounds per cycle, round keys derived backwards
//   HOLD   | plaintext presented until out_ready
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int RPC       = 1,
  parameter int KEY_MODE  = 0,
  parameter int KEY_CACHE = 1
)(
  input logic clk,
  input logic rst_n,
  aes_inv_cipher_iter_if.slave bus
);
  if (!rpc_legal(RPC)) begin : g_bad_rpc
    $error("aes_inv_cipher_iter: RPC must be 1, 2 or 5");
  end

  state_e     state_q, state_d;
  blk_t       st_q, st_d, rk_q, rk_d, ek_q, ek_d;
  logic [3:0] r_q, r_d, ctr_q, ctr_d;
  blk_t       out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  blk_t       cache_key_q, cache_key_d, cache_rk_q, cache_rk_d;
  logic       cache_vld_q, cache_vld_d;
  blk_t       ek_next;
  logic       cache_hit;

  for (genvar g = 0; g < RPC; g++) begin : g_round
    logic [3:0] ri;
    blk_t       st_in, rk_in, k_r, t, st_out;
    if (g == 0) begin : g_first
      assign st_in = st_q;
      assign rk_in = rk_q;
    end else begin : g_next
      assign st_in = g_round[g-1].st_out;
      assign rk_in = g_round[g-1].k_r;
    end
    assign ri = r_q - 4'(g);
    inv_key_step u_ks (.k_next_i(rk_in), .rcon_i(rcon(ri + 4'd1)), .k_o(k_r));
    assign t      = inv_sub_bytes(inv_shift_rows(st_in)) ^ k_r;
    assign st_out = (ri == 4'd0) ? t : inv_mix_columns(t);
  end

  assign ek_next   = key_exp_step(ek_q, rcon(ctr_q + 4'd1));
  assign cache_hit = (KEY_CACHE != 0) && cache_vld_q && (bus.in_key == cache_key_q);

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    ek_d        = ek_q;
    r_d         = r_q;
    ctr_d       = ctr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        if (KEY_MODE == 1) begin
          st_d    = bus.in_data ^ bus.in_key;
          rk_d    = bus.in_key;
          r_d     = 4'(NR - 1);
          state_d = ST_ROUND;
        end else if (cache_hit) begin
          st_d    = bus.in_data ^ cache_rk_q;
          rk_d    = cache_rk_q;
          r_d     = 4'(NR - 1);
          state_d = ST_ROUND;
        end else begin
          // ciphertext parks in st_q; cache entry is invalid until expansion completes
          st_d        = bus.in_data;
          ek_d        = bus.in_key;
          ctr_d       = 4'd0;
          cache_key_d = bus.in_key;
          cache_vld_d = 1'b0;
          state_d     = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        ek_d  = ek_next;
        ctr_d = ctr_q + 4'd1;
        if (ctr_q == 4'(NR - 1)) begin
          st_d        = st_q ^ ek_next;
          rk_d        = ek_next;
          cache_rk_d  = ek_next;
          cache_vld_d = 1'b1;
          r_d         = 4'(NR - 1);
          state_d     = ST_ROUND;
        end
      end
      ST_ROUND: begin
        st_d = g_round[RPC-1].st_out;
        rk_d = g_round[RPC-1].k_r;
        r_d  = r_q - 4'(RPC);
        if (r_q == 4'(RPC - 1)) begin
          out_data_d  = g_round[RPC-1].st_out;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      ek_q        <= '0;
      r_q         <= '0;
      ctr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      ek_q        <= ek_d;
      r_q         <= r_d;
      ctr_q       <= ctr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: three configurations checked against a table-driven
// FIPS-style AES-128 reference decryptor.
module tb_aes_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors;
  int   miscompares;

  always #5 clk = ~clk;

  aes_inv_cipher_iter_if b0 ();
  aes_inv_cipher_iter_if b1 ();
  aes_inv_cipher_iter_if b2 ();

  aes_inv_cipher_iter #(.RPC(1), .KEY_MODE(0), .KEY_CACHE(1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  aes_inv_cipher_iter #(.RPC(2), .KEY_MODE(1), .KEY_CACHE(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  aes_inv_cipher_iter #(.RPC(5), .KEY_MODE(1), .KEY_CACHE(1)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    rk = round_key(key, 10);
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ rk[127-8*b -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      rk = round_key(key, rnd);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c-r+4)%4)];
      for (int b = 0; b < 16; b++) s[b] = isb[t[b]] ^ rk[127-8*b -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul(a0,8'h0e) ^ mul(a1,8'h0b) ^ mul(a2,8'h0d) ^ mul(a3,8'h09);
          s[4*c+1] = mul(a0,8'h09) ^ mul(a1,8'h0e) ^ mul(a2,8'h0b) ^ mul(a3,8'h0d);
          s[4*c+2] = mul(a0,8'h0d) ^ mul(a1,8'h09) ^ mul(a2,8'h0e) ^ mul(a3,8'h0b);
          s[4*c+3] = mul(a0,8'h0b) ^ mul(a1,8'h0d) ^ mul(a2,8'h09) ^ mul(a3,8'h0e);
        end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [127:0] data, input logic [127:0] key);
    case (d)
      0:       begin b0.in_valid = v; b0.in_data = data; b0.in_key = key; end
      1:       begin b1.in_valid = v; b1.in_data = data; b1.in_key = key; end
      default: begin b2.in_valid = v; b2.in_data = data; b2.in_key = key; end
    endcase
  endtask

  task automatic set_or(input int d, input logic v);
    case (d)
      0:       b0.out_ready = v;
      1:       b1.out_ready = v;
      default: b2.out_ready = v;
    endcase
  endtask

  function automatic logic get_ov(input int d);
    case (d)
      0:       return b0.out_valid;
      1:       return b1.out_valid;
      default: return b2.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0:       return b0.in_ready;
      1:       return b1.in_ready;
      default: return b2.in_ready;
    endcase
  endfunction

  function automatic logic [127:0] get_od(input int d);
    case (d)
      0:       return b0.out_data;
      1:       return b1.out_data;
      default: return b2.out_data;
    endcase
  endfunction

  // Leaves the DUT in HOLD with the plaintext presented; inputs are scrambled after accept.
  task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] key,
                           output int lat, output logic [127:0] pt);
    chk("in_ready_before_accept", 128'(get_ir(d)), 128'd1);
    set_in(d, 1'b1, ct, key);
    @(posedge clk); #1;
    set_in(d, 1'b0, rnd128(), rnd128());
    lat = 0;
    while (!get_ov(d) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    pt = get_od(d);
  endtask

  task automatic release_blk(input int d);
    set_or(d, 1'b1);
    @(posedge clk); #1;
    set_or(d, 1'b0);
    chk("release_out_valid", 128'(get_ov(d)), 128'd0);
  endtask

  initial begin
    int           lat;
    logic [127:0] pt, k, ct, exp_pt, key_a, ct_a;
    localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    vectors = 0;
    miscompares = 0;
    build_sbox();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, '0, '0);
      set_or(d, 1'b0);
    end
    #12;
    chk("rst_in_ready", 128'(b0.in_ready), 128'd1);
    chk("rst_out_valid", 128'(b0.out_valid), 128'd0);
    chk("rst_out_data", b0.out_data, 128'd0);
    chk("rst_busy", 128'(b0.busy), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // cipher-key mode with cache: miss, hit, then a new key misses again
    run_block(0, V1_CT, V1_KEY, lat, pt);
    chk("d0_miss_latency", 128'(lat), 128'd20);
    chk("d0_miss_plaintext", pt, V1_PT);
    release_blk(0);
    run_block(0, V1_CT, V1_KEY, lat, pt);
    chk("d0_hit_latency", 128'(lat), 128'd10);
    chk("d0_hit_plaintext", pt, V1_PT);
    release_blk(0);
    key_a = rnd128();
    ct = rnd128();
    run_block(0, ct, key_a, lat, pt);
    chk("d0_newkey_latency", 128'(lat), 128'd20);
    chk("d0_newkey_plaintext", pt, ref_decrypt(ct, key_a));
    release_blk(0);

    // abort a cache-hit block at r=4, then the same key must miss
    ct_a = rnd128();
    set_in(0, 1'b1, ct_a, key_a);
    @(posedge clk); #1;
    set_in(0, 1'b0, rnd128(), rnd128());
    repeat (5) @(posedge clk);
    #1;
    chk("d0_busy_in_round", 128'(b0.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 128'(b0.in_ready), 128'd1);
    chk("abort_out_valid", 128'(b0.out_valid), 128'd0);
    chk("abort_out_data", b0.out_data, 128'd0);
    chk("abort_busy", 128'(b0.busy), 128'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_output", 128'(b0.out_valid), 128'd0);
    run_block(0, ct_a, key_a, lat, pt);
    chk("d0_post_reset_latency", 128'(lat), 128'd20);
    chk("d0_post_reset_plaintext", pt, ref_decrypt(ct_a, key_a));
    release_blk(0);

    // round-key-10 mode, two rounds per clock
    run_block(1, V2_CT, V2_K10, lat, pt);
    chk("d1_vec_latency", 128'(lat), 128'd5);
    chk("d1_vec_plaintext", pt, V2_PT);
    release_blk(1);

    // backpressure in HOLD with ignored input pulses
    k = rnd128();
    ct = rnd128();
    exp_pt = ref_decrypt(ct, k);
    run_block(1, ct, round_key(k, 10), lat, pt);
    chk("d1_hold_latency", 128'(lat), 128'd5);
    chk("d1_hold_plaintext", pt, exp_pt);
    for (int i = 0; i < 7; i++) begin
      set_in(1, 1'b1, rnd128(), rnd128());
      @(posedge clk); #1;
      chk("hold_out_data", b1.out_data, exp_pt);
      chk("hold_out_valid", 128'(b1.out_valid), 128'd1);
      chk("hold_in_ready", 128'(b1.in_ready), 128'd0);
    end
    set_in(1, 1'b0, '0, '0);
    set_or(1, 1'b1);
    @(posedge clk); #1;
    set_or(1, 1'b0);
    chk("hold_exit_out_valid", 128'(b1.out_valid), 128'd0);
    chk("hold_exit_busy", 128'(b1.busy), 128'd0);
    chk("hold_exit_in_ready", 128'(b1.in_ready), 128'd1);
    @(posedge clk); #1;
    chk("hold_no_capture", 128'(b1.busy), 128'd0);
    run_block(1, V2_CT, V2_K10, lat, pt);
    chk("d1_after_hold_plaintext", pt, V2_PT);
    release_blk(1);

    // five rounds per clock, random keys and blocks
    for (int i = 0; i < 10; i++) begin
      k = rnd128();
      ct = rnd128();
      run_block(2, ct, round_key(k, 10), lat, pt);
      chk("d2_rand_latency", 128'(lat), 128'd2);
      chk("d2_rand_plaintext", pt, ref_decrypt(ct, k));
      release_blk(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
